// File: rtl/legv8_pkg.sv
// rtl/legv8_pkg.sv - shared encodings, opcodes and control-word layout for the LEGv8 sequencer
package legv8_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_EXEC   = 3'd2,
        ST_BRANCH = 3'd3,
        ST_HALT   = 3'd4
    } state_e;

    typedef enum logic [2:0] {
        CLS_R, CLS_I, CLS_LD, CLS_ST, CLS_B, CLS_CBZ, CLS_CBNZ, CLS_BAD
    } cls_e;

    localparam logic [4:0] FS_AND   = 5'b00000;
    localparam logic [4:0] FS_ORR   = 5'b00100;
    localparam logic [4:0] FS_ADD   = 5'b01000;
    localparam logic [4:0] FS_SUB   = 5'b01001;
    localparam logic [4:0] FS_EOR   = 5'b01100;
    localparam logic [4:0] FS_PASSA = 5'b10000;

    localparam logic [1:0] DS_ALU = 2'b00;
    localparam logic [1:0] DS_B   = 2'b01;
    localparam logic [1:0] DS_PC  = 2'b10;
    localparam logic [1:0] DS_MEM = 2'b11;
    localparam logic       AS_ALU = 1'b0;
    localparam logic       AS_PC  = 1'b1;
    localparam logic [1:0] PS_HOLD = 2'b00;
    localparam logic [1:0] PS_INC  = 2'b01;
    localparam logic [1:0] PS_BR   = 2'b10;
    localparam logic [1:0] SZ_32 = 2'b10;
    localparam logic [1:0] SZ_64 = 2'b11;

    localparam logic [10:0] OP_ADD  = 11'b10001011000;
    localparam logic [10:0] OP_SUB  = 11'b11001011000;
    localparam logic [10:0] OP_AND  = 11'b10001010000;
    localparam logic [10:0] OP_ORR  = 11'b10101010000;
    localparam logic [10:0] OP_EOR  = 11'b11001010000;
    localparam logic [10:0] OP_LDUR = 11'b11111000010;
    localparam logic [10:0] OP_STUR = 11'b11111000000;
    localparam logic [9:0]  OP_ADDI = 10'b1001000100;
    localparam logic [9:0]  OP_SUBI = 10'b1101000100;
    localparam logic [5:0]  OP_B    = 6'b000101;
    localparam logic [7:0]  OP_CBZ  = 8'b10110100;
    localparam logic [7:0]  OP_CBNZ = 8'b10110101;

    localparam int CW_SB_LSB    = 0;
    localparam int CW_SA_LSB    = 5;
    localparam int CW_DA_LSB    = 10;
    localparam int CW_RW_BIT    = 15;
    localparam int CW_MW_BIT    = 16;
    localparam int CW_SIZE_LSB  = 17;
    localparam int CW_C0_BIT    = 19;
    localparam int CW_FS_LSB    = 20;
    localparam int CW_SL_BIT    = 25;
    localparam int CW_IL_BIT    = 26;
    localparam int CW_BSEL_BIT  = 27;
    localparam int CW_PCSEL_BIT = 28;
    localparam int CW_PS_LSB    = 29;
    localparam int CW_DS_LSB    = 31;
    localparam int CW_AS_BIT    = 33;
    localparam int CW_BITS      = 34;

    // Field order matches the offsets above, MSB first.
    typedef struct packed {
        logic       a_sel;
        logic [1:0] ds;
        logic [1:0] ps;
        logic       pc_sel;
        logic       b_sel;
        logic       il;
        logic       sl;
        logic [4:0] fs;
        logic       c0;
        logic [1:0] size;
        logic       mw;
        logic       rw;
        logic [4:0] da;
        logic [4:0] sa;
        logic [4:0] sb;
    } cw_t;

    typedef struct packed {
        cls_e        cls;
        logic [4:0]  rd;
        logic [4:0]  rn;
        logic [4:0]  rm;
        logic [4:0]  fs;
        logic        c0;
        logic [63:0] imm;
    } dec_t;

    function automatic cw_t fetch_word();
        cw_t w;
        w       = '0;
        w.a_sel = AS_PC;
        w.ds    = DS_MEM;
        w.size  = SZ_32;
        w.il    = 1'b1;
        w.ps    = PS_INC;
        return w;
    endfunction

endpackage

// File: rtl/legv8_decoder.sv
// rtl/legv8_decoder.sv - combinational instruction classifier and immediate extender
module legv8_decoder
    import legv8_pkg::*;
(
    input  logic [31:0] instr_i,
    output dec_t        dec_o
);

    always_comb begin
        dec_o     = '0;
        dec_o.cls = CLS_BAD;
        dec_o.rd  = instr_i[4:0];
        dec_o.rn  = instr_i[9:5];
        dec_o.rm  = instr_i[20:16];
        if (instr_i[31:21] == OP_ADD) begin
            dec_o.cls = CLS_R;
            dec_o.fs  = FS_ADD;
        end else if (instr_i[31:21] == OP_SUB) begin
            dec_o.cls = CLS_R;
            dec_o.fs  = FS_SUB;
            dec_o.c0  = 1'b1;
        end else if (instr_i[31:21] == OP_AND) begin
            dec_o.cls = CLS_R;
            dec_o.fs  = FS_AND;
        end else if (instr_i[31:21] == OP_ORR) begin
            dec_o.cls = CLS_R;
            dec_o.fs  = FS_ORR;
        end else if (instr_i[31:21] == OP_EOR) begin
            dec_o.cls = CLS_R;
            dec_o.fs  = FS_EOR;
        end else if (instr_i[31:22] == OP_ADDI || instr_i[31:22] == OP_SUBI) begin
            dec_o.cls = CLS_I;
            dec_o.fs  = (instr_i[31:22] == OP_SUBI) ? FS_SUB : FS_ADD;
            dec_o.c0  = (instr_i[31:22] == OP_SUBI);
            dec_o.imm = {52'd0, instr_i[21:10]};
        end else if (instr_i[31:21] == OP_LDUR || instr_i[31:21] == OP_STUR) begin
            dec_o.cls = (instr_i[31:21] == OP_LDUR) ? CLS_LD : CLS_ST;
            dec_o.fs  = FS_ADD;
            dec_o.imm = {{55{instr_i[20]}}, instr_i[20:12]};
        end else if (instr_i[31:26] == OP_B) begin
            // PC was already advanced by 4 during FETCH, so pre-subtract it.
            dec_o.cls = CLS_B;
            dec_o.imm = {{36{instr_i[25]}}, instr_i[25:0], 2'b00} - 64'd4;
        end else if (instr_i[31:24] == OP_CBZ || instr_i[31:24] == OP_CBNZ) begin
            dec_o.cls = (instr_i[31:24] == OP_CBZ) ? CLS_CBZ : CLS_CBNZ;
            dec_o.fs  = FS_PASSA;
            dec_o.imm = {{43{instr_i[23]}}, instr_i[23:5], 2'b00} - 64'd4;
        end
    end

endmodule

// File: rtl/legv8_control_unit.sv
// rtl/legv8_control_unit.sv - multi-cycle FETCH/EXEC/BRANCH sequencer driving the LEGv8 control word
module legv8_control_unit
    import legv8_pkg::*;
#(
    parameter int CW_WIDTH  = 34,
    parameter int CNT_WIDTH = 32
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 run,
    input  logic [31:0]          instruction,
    input  logic [4:0]           status,
    output logic [CW_WIDTH-1:0]  control_word,
    output logic [63:0]          constant,
    output logic [2:0]           state,
    output logic                 halted,
    output logic [CNT_WIDTH-1:0] instr_count
);

    state_e               state_q, state_d;
    cw_t                  cw_q, cw_d;
    logic [63:0]          const_q, const_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic                 z_q, z_d;
    logic                 take_d;
    dec_t                 dec;
    logic                 unused_status;

    assign unused_status = ^status[4:1];

    legv8_decoder u_dec (
        .instr_i (instruction),
        .dec_o   (dec)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cw_q    <= '0;
            const_q <= '0;
            cnt_q   <= '0;
            z_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            cw_q    <= cw_d;
            const_q <= const_d;
            cnt_q   <= cnt_d;
            z_q     <= z_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        z_d     = z_q;
        case (state_q)
            ST_IDLE: if (run) state_d = ST_FETCH;
            ST_FETCH: state_d = ST_EXEC;
            ST_EXEC: begin
                case (dec.cls)
                    CLS_B: state_d = ST_BRANCH;
                    CLS_CBZ, CLS_CBNZ: begin
                        z_d     = status[0];
                        state_d = ST_BRANCH;
                    end
                    CLS_BAD: state_d = ST_HALT;
                    default: begin
                        cnt_d   = cnt_q + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
                        state_d = run ? ST_FETCH : ST_IDLE;
                    end
                endcase
            end
            ST_BRANCH: begin
                cnt_d   = cnt_q + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
                state_d = run ? ST_FETCH : ST_IDLE;
            end
            ST_HALT: state_d = ST_HALT;
            default: state_d = ST_IDLE;
        endcase
    end

    assign take_d = (dec.cls == CLS_B) ||
                    (dec.cls == CLS_CBZ && z_d) ||
                    (dec.cls == CLS_CBNZ && !z_d);

    // Outputs are registered, so the word is built for the state being entered.
    always_comb begin
        cw_d    = '0;
        const_d = '0;
        case (state_d)
            ST_FETCH: cw_d = fetch_word();
            ST_EXEC: begin
                case (dec.cls)
                    CLS_R: begin
                        cw_d.fs = dec.fs;
                        cw_d.c0 = dec.c0;
                        cw_d.sa = dec.rn;
                        cw_d.sb = dec.rm;
                        cw_d.da = dec.rd;
                        cw_d.rw = 1'b1;
                        cw_d.ds = DS_ALU;
                    end
                    CLS_I: begin
                        cw_d.fs    = dec.fs;
                        cw_d.c0    = dec.c0;
                        cw_d.b_sel = 1'b1;
                        cw_d.sa    = dec.rn;
                        cw_d.da    = dec.rd;
                        cw_d.rw    = 1'b1;
                        const_d    = dec.imm;
                    end
                    CLS_LD, CLS_ST: begin
                        cw_d.fs    = dec.fs;
                        cw_d.b_sel = 1'b1;
                        cw_d.a_sel = AS_ALU;
                        cw_d.size  = SZ_64;
                        cw_d.sa    = dec.rn;
                        const_d    = dec.imm;
                        if (dec.cls == CLS_LD) begin
                            cw_d.ds = DS_MEM;
                            cw_d.rw = 1'b1;
                            cw_d.da = dec.rd;
                        end else begin
                            cw_d.ds = DS_B;
                            cw_d.mw = 1'b1;
                            cw_d.sb = dec.rd;
                        end
                    end
                    CLS_CBZ, CLS_CBNZ: begin
                        cw_d.fs = dec.fs;
                        cw_d.sa = dec.rd;
                    end
                    default: ;
                endcase
            end
            ST_BRANCH: begin
                if (take_d) begin
                    cw_d.ps     = PS_BR;
                    cw_d.pc_sel = 1'b1;
                    const_d     = dec.imm;
                end
            end
            default: ;
        endcase
    end

    assign control_word = cw_q;
    assign constant     = const_q;
    assign state        = state_q;
    assign halted       = (state_q == ST_HALT);
    assign instr_count  = cnt_q;

endmodule

// File: tb/tb_legv8_control_unit.sv
// tb/tb_legv8_control_unit.sv - scoreboard bench for the LEGv8 control unit
module tb_legv8_control_unit;

    logic        clock, reset, run;
    logic [31:0] instruction;
    logic [4:0]  status;
    logic [33:0] control_word;
    logic [63:0] constant;
    logic [2:0]  state;
    logic        halted;
    logic [5:0]  instr_count;

    legv8_control_unit #(.CW_WIDTH(34), .CNT_WIDTH(6)) dut (
        .clock        (clock),
        .reset        (reset),
        .run          (run),
        .instruction  (instruction),
        .status       (status),
        .control_word (control_word),
        .constant     (constant),
        .state        (state),
        .halted       (halted),
        .instr_count  (instr_count)
    );

    typedef struct {
        logic [2:0]  st;
        logic [33:0] cw;
        logic [63:0] k;
        logic [5:0]  cnt;
        logic        h;
    } rec_t;

    typedef struct {
        logic [31:0] ins;
        int          z;
        bit          stop;
    } pitem_t;

    localparam logic [33:0] FETCH_CW = {1'b1, 2'b11, 2'b01, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0,
                                        1'b0, 2'b10, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0};

    rec_t   exq[$];
    pitem_t prog[$];
    int     nchk = 0;
    int     nerr = 0;
    int     cnt  = 0;
    bit     mon_en = 0;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [33:0] mk(input logic a, input logic [1:0] ds, input logic [1:0] ps,
                                       input logic bs, input logic [4:0] fs, input logic c0,
                                       input logic [1:0] sz, input logic mw, input logic rw,
                                       input logic [4:0] da, input logic [4:0] sa, input logic [4:0] sb);
        return {a, ds, ps, ps[1], bs, 1'b0, 1'b0, fs, c0, sz, mw, rw, da, sa, sb};
    endfunction

    // kind: 0 counted data op, 1 B, 2 CBZ, 3 CBNZ, 4 illegal
    function automatic void model_exec(input logic [31:0] i, output int kind, output logic [33:0] cw,
                                       output logic [63:0] k, output logic [63:0] boff);
        logic [4:0] rd, rn, rm;
        logic signed [8:0]  s9;
        logic signed [18:0] s19;
        logic signed [25:0] s26;
        rd = i[4:0]; rn = i[9:5]; rm = i[20:16];
        s9 = i[20:12]; s19 = i[23:5]; s26 = i[25:0];
        kind = 4; cw = '0; k = '0; boff = '0;
        case (i[31:21])
            11'b10001011000: begin kind = 0; cw = mk(1'b0, 2'b00, 2'b00, 1'b0, 5'b01000, 1'b0, 2'b00, 1'b0, 1'b1, rd, rn, rm); end
            11'b11001011000: begin kind = 0; cw = mk(1'b0, 2'b00, 2'b00, 1'b0, 5'b01001, 1'b1, 2'b00, 1'b0, 1'b1, rd, rn, rm); end
            11'b10001010000: begin kind = 0; cw = mk(1'b0, 2'b00, 2'b00, 1'b0, 5'b00000, 1'b0, 2'b00, 1'b0, 1'b1, rd, rn, rm); end
            11'b10101010000: begin kind = 0; cw = mk(1'b0, 2'b00, 2'b00, 1'b0, 5'b00100, 1'b0, 2'b00, 1'b0, 1'b1, rd, rn, rm); end
            11'b11001010000: begin kind = 0; cw = mk(1'b0, 2'b00, 2'b00, 1'b0, 5'b01100, 1'b0, 2'b00, 1'b0, 1'b1, rd, rn, rm); end
            11'b11111000010: begin kind = 0; k = longint'(s9);
                cw = mk(1'b0, 2'b11, 2'b00, 1'b1, 5'b01000, 1'b0, 2'b11, 1'b0, 1'b1, rd, rn, 5'd0); end
            11'b11111000000: begin kind = 0; k = longint'(s9);
                cw = mk(1'b0, 2'b01, 2'b00, 1'b1, 5'b01000, 1'b0, 2'b11, 1'b1, 1'b0, 5'd0, rn, rd); end
            default: ;
        endcase
        if (kind == 4) begin
            if (i[31:22] == 10'b1001000100) begin
                kind = 0; k = {52'd0, i[21:10]};
                cw = mk(1'b0, 2'b00, 2'b00, 1'b1, 5'b01000, 1'b0, 2'b00, 1'b0, 1'b1, rd, rn, 5'd0);
            end else if (i[31:22] == 10'b1101000100) begin
                kind = 0; k = {52'd0, i[21:10]};
                cw = mk(1'b0, 2'b00, 2'b00, 1'b1, 5'b01001, 1'b1, 2'b00, 1'b0, 1'b1, rd, rn, 5'd0);
            end else if (i[31:26] == 6'b000101) begin
                kind = 1; boff = longint'(s26) * 4 - 4;
            end else if (i[31:24] == 8'hB4 || i[31:24] == 8'hB5) begin
                kind = (i[31:24] == 8'hB4) ? 2 : 3; boff = longint'(s19) * 4 - 4;
                cw = mk(1'b0, 2'b00, 2'b00, 1'b0, 5'b10000, 1'b0, 2'b00, 1'b0, 1'b0, 5'd0, rd, 5'd0);
            end
        end
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [10:0] rops [5];
        logic [31:0] r;
        int c;
        rops = '{11'b10001011000, 11'b11001011000, 11'b10001010000, 11'b10101010000, 11'b11001010000};
        r = $urandom;
        c = $urandom_range(0, 9);
        case (c)
            0, 7: r[31:21] = rops[$urandom_range(0, 4)];
            1, 8: r[31:22] = ($urandom_range(0, 1) != 0) ? 10'b1001000100 : 10'b1101000100;
            2, 9: r[31:21] = 11'b11111000010;
            3:    r[31:21] = 11'b11111000000;
            4:    r[31:26] = 6'b000101;
            5:    r[31:24] = 8'hB4;
            default: r[31:24] = 8'hB5;
        endcase
        return r;
    endfunction

    task automatic wait_state(input logic [2:0] s, output bit ok);
        int n;
        ok = 0;
        n = 0;
        while (!ok && n < 8) begin
            @(posedge clock); #1;
            if (state == s) ok = 1;
            n++;
        end
        if (!ok) begin
            nchk++;
            nerr++;
            $display("FAIL wait_state: got state %0d, expected %0d within 8 cycles", state, s);
        end
    endtask

    always @(negedge clock) begin : monitor
        rec_t r;
        if (mon_en && !reset && state != 3'd0) begin
            if (exq.size() == 0) begin
                nchk++;
                nerr++;
                $display("FAIL scoreboard_underflow: got state %0d, expected no output", state);
            end else begin
                r = exq.pop_front();
                chk("mon.state", {61'd0, state}, {61'd0, r.st});
                chk("mon.control_word", {30'd0, control_word}, {30'd0, r.cw});
                chk("mon.constant", constant, r.k);
                chk("mon.instr_count", {58'd0, instr_count}, {58'd0, r.cnt});
                chk("mon.halted", {63'd0, halted}, {63'd0, r.h});
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        bit ok;
        int kind;
        logic [33:0] ecw;
        logic [63:0] ek, boff;
        logic zb;
        bit taken;

        reset = 1'b1; run = 1'b0; instruction = '0; status = '0;
        repeat (3) @(posedge clock);
        #1;
        chk("rst.state", {61'd0, state}, 64'd0);
        chk("rst.control_word", {30'd0, control_word}, 64'd0);
        chk("rst.constant", constant, 64'd0);
        chk("rst.instr_count", {58'd0, instr_count}, 64'd0);
        chk("rst.halted", {63'd0, halted}, 64'd0);
        reset = 1'b0;
        @(posedge clock); #1;
        chk("idle_without_run", {61'd0, state}, 64'd0);

        prog.push_back('{32'h910017E1, -1, 1'b0});
        prog.push_back('{32'h8B020023, -1, 1'b0});
        prog.push_back('{32'hF8408024, -1, 1'b0});
        prog.push_back('{32'hF8008024, -1, 1'b1});
        prog.push_back('{32'h17FFFFFE, -1, 1'b0});
        prog.push_back('{32'hB4000065,  1, 1'b0});
        prog.push_back('{32'hB4000065,  0, 1'b1});
        prog.push_back('{32'hB5000065,  0, 1'b0});
        for (int n = 0; n < 200; n++)
            prog.push_back('{rand_instr(), -1, ($urandom_range(0, 15) == 0)});
        prog.push_back('{32'h00000000, -1, 1'b0});

        mon_en = 1;
        run = 1'b1;
        for (int p = 0; p < prog.size(); p++) begin
            wait_state(3'd1, ok);
            if (!ok) break;
            model_exec(prog[p].ins, kind, ecw, ek, boff);
            instruction = prog[p].ins;
            exq.push_back('{3'd1, FETCH_CW, 64'd0, cnt[5:0], 1'b0});
            exq.push_back('{3'd2, ecw, ek, cnt[5:0], 1'b0});
            if (kind == 0) cnt++;
            @(posedge clock); #1;
            zb = (prog[p].z < 0) ? 1'($urandom_range(0, 1)) : prog[p].z[0];
            status = {4'($urandom), zb};
            if (prog[p].stop) run = 1'b0;
            if (kind >= 1 && kind <= 3) begin
                taken = (kind == 1) || (kind == 2 && zb) || (kind == 3 && !zb);
                exq.push_back('{3'd3,
                                taken ? mk(1'b0, 2'b00, 2'b10, 1'b0, 5'd0, 1'b0, 2'b00, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0) : 34'd0,
                                taken ? boff : 64'd0, cnt[5:0], 1'b0});
                cnt++;
            end
            if (kind == 4) begin
                for (int h = 0; h < 10; h++) exq.push_back('{3'd4, 34'd0, 64'd0, cnt[5:0], 1'b1});
                repeat (10) @(posedge clock);
                #6;
            end
            if (prog[p].stop) begin
                repeat ((kind >= 1 && kind <= 3) ? 2 : 1) @(posedge clock);
                #1;
                chk("idle_after_run_drop", {61'd0, state}, 64'd0);
                run = 1'b1;
            end
        end
        mon_en = 0;
        chk("scoreboard_drained", 64'(exq.size()), 64'd0);

        reset = 1'b1;
        @(posedge clock); #1;
        chk("halt_cleared.halted", {63'd0, halted}, 64'd0);
        chk("halt_cleared.count", {58'd0, instr_count}, 64'd0);
        reset = 1'b0;
        run = 1'b1;
        instruction = 32'hF8008024;
        wait_state(3'd2, ok);
        if (ok) begin
            chk("stur.mw_before_reset", {63'd0, control_word[16]}, 64'd1);
            #2 reset = 1'b1;
            #1;
            chk("abort.control_word", {30'd0, control_word}, 64'd0);
            chk("abort.state", {61'd0, state}, 64'd0);
            @(posedge clock); #1;
            chk("abort.state_held", {61'd0, state}, 64'd0);
        end
        reset = 1'b0;
        run = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end

endmodule
